// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
// Module   : vend_controller
// Purpose  : Credit-accumulation and dispense controller for the vending
//            machine. Accepts one-cycle coin/select/cancel pulses, keeps a
//            running credit, checks selections against item prices, drives a
//            timed one-hot dispense output and returns change.
// Ports    : clk_i           system clock, rising edge
//            rst_ni          synchronous active-low reset
//            coin_i[2:0]     coin pulses: bit0=10, bit1=20, bit2=50 units
//            sel_i[2:0]      select pulses: bit0=A, bit1=B, bit2=C
//            cancel_i        cancel / refund pulse
//            credit_o[7:0]   current credit
//            dispense_o[2:0] one-hot dispense, held DISP_CYCLES cycles
//            change_valid_o  one-cycle change-return strobe
//            change_amt_o    change amount (0 when change_valid_o is low)
//            coin_reject_o   one-cycle strobe: coin not accepted
//            insufficient_o  one-cycle strobe: selection lacked credit
//            busy_o          high while dispensing or returning change
// Revision : 1.0 - initial release
// ============================================================================
module vend_controller #(
  parameter int PRICE_A     = 30,
  parameter int PRICE_B     = 50,
  parameter int PRICE_C     = 70,
  parameter int MAX_CREDIT  = 200,
  parameter int DISP_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] coin_i,
  input  logic [2:0] sel_i,
  input  logic       cancel_i,
  output logic [7:0] credit_o,
  output logic [2:0] dispense_o,
  output logic       change_valid_o,
  output logic [7:0] change_amt_o,
  output logic       coin_reject_o,
  output logic       insufficient_o,
  output logic       busy_o
);

  // Counter only needs to hold DISP_CYCLES-1.
  localparam int CNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DISP_CYCLES - 1);
  localparam logic [8:0] MAX9 = 9'(MAX_CREDIT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CREDIT   = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       credit_q, credit_d;
  logic [2:0]       dispense_q, dispense_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             change_valid_q, change_valid_d;
  logic [7:0]       change_amt_q, change_amt_d;
  logic             coin_reject_q, coin_reject_d;
  logic             insufficient_q, insufficient_d;
  logic             busy_q, busy_d;

  // Decoded coin value and item price; 9-bit arithmetic avoids wrap.
  logic [8:0] coin_val;
  logic       coin_onehot;
  logic       coin_any;
  logic [8:0] price;
  logic       sel_onehot;
  logic [8:0] credit9;
  logic [8:0] coin_sum;
  logic [8:0] credit_left;

  always_comb begin
    coin_val    = 9'd0;
    coin_onehot = 1'b1;
    case (coin_i)
      3'b001:  coin_val = 9'd10;
      3'b010:  coin_val = 9'd20;
      3'b100:  coin_val = 9'd50;
      default: coin_onehot = 1'b0;
    endcase
  end

  always_comb begin
    price      = 9'd0;
    sel_onehot = 1'b1;
    case (sel_i)
      3'b001:  price = 9'(PRICE_A);
      3'b010:  price = 9'(PRICE_B);
      3'b100:  price = 9'(PRICE_C);
      default: sel_onehot = 1'b0;
    endcase
  end

  assign coin_any    = |coin_i;
  assign credit9     = {1'b0, credit_q};
  assign coin_sum    = credit9 + coin_val;
  assign credit_left = credit9 - price;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      credit_q       <= 8'd0;
      dispense_q     <= 3'd0;
      cnt_q          <= '0;
      change_valid_q <= 1'b0;
      change_amt_q   <= 8'd0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      dispense_q     <= dispense_d;
      cnt_q          <= cnt_d;
      change_valid_q <= change_valid_d;
      change_amt_q   <= change_amt_d;
      coin_reject_q  <= coin_reject_d;
      insufficient_q <= insufficient_d;
      busy_q         <= busy_d;
    end
  end

  // The change cycle's outputs are loaded on the edge that enters S_CHANGE,
  // so change_valid/credit=0 appear together for exactly the CHANGE cycle.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    dispense_d     = dispense_q;
    cnt_d          = cnt_q;
    change_valid_d = 1'b0;
    change_amt_d   = 8'd0;
    coin_reject_d  = 1'b0;
    insufficient_d = 1'b0;
    busy_d         = busy_q;

    case (state_q)
      S_IDLE, S_CREDIT: begin
        busy_d = 1'b0;
        if (cancel_i) begin
          // A coin arriving with cancel is dropped.
          coin_reject_d = coin_any;
          if (credit_q != 8'd0) begin
            state_d        = S_CHANGE;
            change_valid_d = 1'b1;
            change_amt_d   = credit_q;
            credit_d       = 8'd0;
            busy_d         = 1'b1;
          end
        end else if (sel_onehot) begin
          // A coin arriving with a valid selection is dropped.
          coin_reject_d = coin_any;
          if (credit9 >= price) begin
            credit_d   = credit_left[7:0];
            dispense_d = sel_i;
            cnt_d      = CNT_LOAD;
            state_d    = S_DISPENSE;
            busy_d     = 1'b1;
          end else begin
            insufficient_d = 1'b1;
          end
        end else if (coin_any) begin
          if (coin_onehot && (coin_sum <= MAX9)) begin
            credit_d = coin_sum[7:0];
            state_d  = S_CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end

      S_DISPENSE: begin
        coin_reject_d = coin_any;
        if (cnt_q == '0) begin
          dispense_d = 3'd0;
          if (credit_q != 8'd0) begin
            state_d        = S_CHANGE;
            change_valid_d = 1'b1;
            change_amt_d   = credit_q;
            credit_d       = 8'd0;
            busy_d         = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_CHANGE: begin
        coin_reject_d = coin_any;
        state_d       = S_IDLE;
        busy_d        = 1'b0;
      end

      default: begin
        state_d    = S_IDLE;
        credit_d   = 8'd0;
        dispense_d = 3'd0;
        busy_d     = 1'b0;
      end
    endcase
  end

  assign credit_o       = credit_q;
  assign dispense_o     = dispense_q;
  assign change_valid_o = change_valid_q;
  assign change_amt_o   = change_amt_q;
  assign coin_reject_o  = coin_reject_q;
  assign insufficient_o = insufficient_q;
  assign busy_o         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_controller
// Purpose  : Directed self-checking bench for vend_controller. Each step
//            applies one cycle of pulses, then checks the registered outputs
//            1 time unit after the rising edge against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_controller;

  logic       clk;
  logic       rst_n;
  logic [2:0] coin;
  logic [2:0] sel;
  logic       cancel;
  logic [7:0] credit;
  logic [2:0] dispense;
  logic       change_valid;
  logic [7:0] change_amt;
  logic       coin_reject;
  logic       insufficient;
  logic       busy;

  int n_total = 0;
  int n_pass  = 0;

  vend_controller #(
    .PRICE_A    (30),
    .PRICE_B    (50),
    .PRICE_C    (70),
    .MAX_CREDIT (200),
    .DISP_CYCLES(4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .coin_i        (coin),
    .sel_i         (sel),
    .cancel_i      (cancel),
    .credit_o      (credit),
    .dispense_o    (dispense),
    .change_valid_o(change_valid),
    .change_amt_o  (change_amt),
    .coin_reject_o (coin_reject),
    .insufficient_o(insufficient),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Drive one cycle of pulses across a rising edge, then land 1 unit after it.
  task automatic step(input logic [2:0] c, input logic [2:0] s, input logic x);
    coin   = c;
    sel    = s;
    cancel = x;
    @(posedge clk);
    #1;
    coin   = 3'd0;
    sel    = 3'd0;
    cancel = 1'b0;
  endtask

  task automatic idle();
    step(3'd0, 3'd0, 1'b0);
  endtask

  initial begin
    coin   = 3'd0;
    sel    = 3'd0;
    cancel = 1'b0;
    rst_n  = 1'b0;
    idle();
    idle();

    // Reset state
    check("rst_credit", credit, 0);
    check("rst_dispense", dispense, 0);
    check("rst_busy", busy, 0);
    check("rst_change_valid", change_valid, 0);
    check("rst_change_amt", change_amt, 0);
    check("rst_coin_reject", coin_reject, 0);
    check("rst_insufficient", insufficient, 0);
    rst_n = 1'b1;
    idle();

    // Purchase with change: 20 + 20, buy A (30) -> 10 change
    step(3'b010, 3'd0, 1'b0);
    check("pwc_credit20", credit, 20);
    step(3'b010, 3'd0, 1'b0);
    check("pwc_credit40", credit, 40);
    step(3'd0, 3'b001, 1'b0);
    check("pwc_credit10", credit, 10);
    check("pwc_disp_c1", dispense, 3'b001);
    check("pwc_busy_c1", busy, 1);
    idle();
    check("pwc_disp_c2", dispense, 3'b001);
    idle();
    check("pwc_disp_c3", dispense, 3'b001);
    idle();
    check("pwc_disp_c4", dispense, 3'b001);
    check("pwc_no_chg_c4", change_valid, 0);
    idle();
    check("pwc_chg_valid", change_valid, 1);
    check("pwc_chg_amt", change_amt, 10);
    check("pwc_chg_credit", credit, 0);
    check("pwc_chg_disp", dispense, 0);
    check("pwc_chg_busy", busy, 1);
    idle();
    check("pwc_after_valid", change_valid, 0);
    check("pwc_after_amt", change_amt, 0);
    check("pwc_after_busy", busy, 0);

    // Exact price: 50, buy B -> no change
    step(3'b100, 3'd0, 1'b0);
    check("ex_credit50", credit, 50);
    step(3'd0, 3'b010, 1'b0);
    check("ex_credit0", credit, 0);
    check("ex_disp_c1", dispense, 3'b010);
    idle();
    idle();
    idle();
    check("ex_disp_c4", dispense, 3'b010);
    check("ex_busy_c4", busy, 1);
    idle();
    check("ex_disp_end", dispense, 0);
    check("ex_busy_end", busy, 0);
    check("ex_no_change", change_valid, 0);

    // Insufficient then cancel
    step(3'b100, 3'd0, 1'b0);
    step(3'd0, 3'b100, 1'b0);
    check("ins_strobe", insufficient, 1);
    check("ins_credit", credit, 50);
    check("ins_no_disp", dispense, 0);
    idle();
    check("ins_strobe_gone", insufficient, 0);
    step(3'd0, 3'd0, 1'b1);
    check("can_valid", change_valid, 1);
    check("can_amt", change_amt, 50);
    check("can_credit", credit, 0);
    idle();
    check("can_busy_off", busy, 0);

    // Saturation (back-to-back coins) and illegal coins
    step(3'b100, 3'd0, 1'b0);
    check("sat_50", credit, 50);
    step(3'b100, 3'd0, 1'b0);
    check("sat_100", credit, 100);
    step(3'b100, 3'd0, 1'b0);
    check("sat_150", credit, 150);
    step(3'b100, 3'd0, 1'b0);
    check("sat_200", credit, 200);
    check("sat_200_norej", coin_reject, 0);
    step(3'b001, 3'd0, 1'b0);
    check("sat_rej", coin_reject, 1);
    check("sat_rej_credit", credit, 200);
    idle();
    check("sat_rej_gone", coin_reject, 0);
    step(3'b011, 3'd0, 1'b0);
    check("multi_coin_rej", coin_reject, 1);
    check("multi_coin_credit", credit, 200);
    step(3'd0, 3'd0, 1'b1);
    check("sat_refund", change_amt, 200);
    idle();

    // Multi-bit select is ignored
    step(3'b100, 3'd0, 1'b0);
    step(3'd0, 3'b011, 1'b0);
    check("msel_credit", credit, 50);
    check("msel_disp", dispense, 0);
    check("msel_ins", insufficient, 0);

    // Cancel beats select
    step(3'd0, 3'b010, 1'b1);
    check("cvs_valid", change_valid, 1);
    check("cvs_amt", change_amt, 50);
    check("cvs_disp", dispense, 0);
    idle();

    // Coin dropped by accepted select; coin during DISPENSE rejected
    step(3'b100, 3'd0, 1'b0);
    step(3'b001, 3'b001, 1'b0);
    check("cws_rej", coin_reject, 1);
    check("cws_credit", credit, 20);
    check("cws_disp", dispense, 3'b001);
    step(3'b010, 3'd0, 1'b0);
    check("cid_rej", coin_reject, 1);
    check("cid_credit", credit, 20);
    check("cid_disp", dispense, 3'b001);
    idle();
    idle();
    idle();
    check("cid_chg_valid", change_valid, 1);
    check("cid_chg_amt", change_amt, 20);
    idle();

    // Reset during DISPENSE
    step(3'b100, 3'd0, 1'b0);
    step(3'd0, 3'b001, 1'b0);
    check("rd_disp_pre", dispense, 3'b001);
    rst_n = 1'b0;
    idle();
    check("rd_disp", dispense, 0);
    check("rd_credit", credit, 0);
    check("rd_busy", busy, 0);
    check("rd_chg", change_valid, 0);
    idle();
    check("rd_chg2", change_valid, 0);
    rst_n = 1'b1;
    idle();
    idle();
    check("rd_after_chg", change_valid, 0);
    check("rd_after_credit", credit, 0);
    check("rd_after_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vend_controller.md
# vend_controller

Credit-accumulation and dispense controller for the vending machine. It consumes the one-clock-cycle pulses produced by the push-button capture stages: coin buttons, item-select buttons and cancel. It keeps a running credit, checks selections against per-item prices, drives the dispense outputs, and returns change. It sits directly downstream of the button capture stages and upstream of the display/LED drivers.

## Interface
- PRICE_A, 30: price of item A, credit units.
- PRICE_B, 50: price of item B.
- PRICE_C, 70: price of item C.
- MAX_CREDIT, 200: credit ceiling; must be ≤ 255.
- DISP_CYCLES, 4: dispense pulse length in cycles; must be ≥ 1.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- coin  in  3  one-cycle coin pulses: bit0 = 10, bit1 = 20, bit2 = 50 units.
- sel  in  3  one-cycle select pulses: bit0 = A, bit1 = B, bit2 = C.
- cancel  in  1  one-cycle cancel/refund pulse.
- credit  out  8  current credit, registered.
- dispense  out  3  one-hot dispense, held DISP_CYCLES cycles.
- change_valid  out  1  one-cycle change-return strobe.
- change_amt  out  8  change amount; valid only with change_valid, otherwise 0.
- coin_reject  out  1  one-cycle strobe: coin not accepted.
- insufficient  out  1  one-cycle strobe: selection refused for lack of credit.
- busy  out  1  high in DISPENSE and CHANGE.

## Operation
- States:
  - IDLE: credit == 0.
  - CREDIT: credit > 0.
  - DISPENSE
  - CHANGE
- Reset (rst_n low at an edge): state IDLE; credit, dispense, change_valid, change_amt, coin_reject, insufficient and busy all 0. Reset mid-operation aborts any dispense or change; credit is discarded.
- Same-cycle priority in IDLE/CREDIT: cancel > sel > coin.
  - A coin pulse dropped because of a higher-priority event raises coin_reject.
  - A dropped sel has no effect.
- Coin handling (IDLE/CREDIT, no cancel, no valid sel):
  - Exactly one coin bit high and credit + value ≤ MAX_CREDIT: credit += value; state becomes CREDIT.
  - credit + value > MAX_CREDIT: coin_reject; credit unchanged.
  - More than one coin bit high: coin_reject; credit unchanged.
  - Sums are computed 9 bits wide, so no wrap.
- Select handling (IDLE/CREDIT):
  - sel must be one-hot. sel == 0 means no event. Multi-bit sel is ignored with no strobe.
  - credit ≥ price: credit −= price; the matching dispense bit is set; state becomes DISPENSE.
  - credit < price: insufficient strobe; credit and state unchanged.
- Cancel:
  - credit > 0: go to CHANGE.
  - credit == 0: no effect.
- DISPENSE:
  - The dispense bit is held for DISP_CYCLES cycles, counted by an internal down-counter.
  - At the end: go to CHANGE if the remaining credit > 0, otherwise go to IDLE.
- CHANGE:
  - One cycle: change_valid = 1 and change_amt = credit; credit is cleared.
  - Next state is IDLE.
- In DISPENSE/CHANGE:
  - sel and cancel are ignored.
  - Any coin pulse raises coin_reject; credit is unchanged.

## Timing
- All outputs are registered. An input pulse sampled at edge N takes effect at the outputs after edge N.
- Coin accepted at edge N: credit shows the new value from cycle N+1.
- Sel accepted at edge N:
  - dispense and busy high for cycles N+1 … N+DISP_CYCLES.
  - credit shows the reduced value from N+1.
- Change cycle:
  - change_valid is high in cycle N+DISP_CYCLES+1 after a purchase, or in cycle N+1 after a cancel at edge N.
  - credit reads 0 in that same cycle; change_amt holds the pre-clear credit.
- The coin_reject and insufficient strobes are exactly one cycle, in the cycle after the offending pulse.
- busy drops in the cycle after CHANGE, or after DISPENSE when there is no change.
- The block is fully pipelined on pulses: back-to-back coin pulses on consecutive cycles are each accepted.

## Test plan
- Reset: assert rst_n low for 2 cycles during DISPENSE -> dispense = 0, credit = 0, busy = 0 after the first low edge; no change_valid.
- Purchase with change: coin 20, coin 20, sel A -> credit 40 then 10; dispense = 001 for 4 cycles; then change_valid with change_amt = 10; credit 0; IDLE.
- Exact price: coin 50, sel B -> dispense = 010 for 4 cycles; no change_valid; credit 0; busy low after.
- Insufficient then cancel: coin 50, sel C -> insufficient strobe, credit stays 50; cancel -> change_valid with change_amt = 50 next cycle.
- Saturation and illegal coins: 4× coin 50 -> credit 200; coin 10 -> coin_reject, credit 200. coin = 011 -> coin_reject, credit unchanged.
- Same-cycle conflicts:
  - credit 50, sel B and cancel together -> cancel wins, change_amt 50, no dispense.
  - coin 10 together with an accepted sel A -> coin_reject.
  - coin during DISPENSE -> coin_reject, credit unchanged.
